// File: rtl/priv_ret_ctrl.sv
// Privileged-return / WFI controller: decodes SRET/MRET/WFI, checks privilege,
// runs the CSR stack-pop handshake with timeout and issues a one-cycle PC redirect.
module priv_ret_ctrl #(
    parameter logic        HAS_S       = 1'b1,
    parameter logic        HAS_U       = 1'b1,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [11:0] imm_i,
    input  logic [1:0]  cur_priv,
    input  logic        mstatus_tsr,
    input  logic        mstatus_tw,
    input  logic [1:0]  mstatus_mpp,
    input  logic        mstatus_spp,
    input  logic        irq_pending,
    input  logic        kill,
    input  logic        csr_ack,
    output logic        ret_req,
    output logic        ret_is_mret,
    output logic        redirect_valid,
    output logic [1:0]  new_priv,
    output logic        illegal_pulse,
    output logic        fault_pulse,
    output logic        wfi_active,
    output logic        stall
);

    localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] WFI  = 2'd3;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    tgt_priv;

    logic is_sys, is_sret, is_mret, is_wfi;
    logic in_m, in_s;
    logic sret_ok, mret_ok, wfi_ok;

    // Target privilege is captured at decode, before the CSR pop rewrites MPP/SPP.
    function automatic logic [1:0] clamp_mpp(input logic [1:0] mpp);
        logic [1:0] lowest;
        lowest = HAS_U ? PRIV_U : (HAS_S ? PRIV_S : PRIV_M);
        case (mpp)
            2'b11:   clamp_mpp = PRIV_M;
            2'b10:   clamp_mpp = lowest;
            2'b01:   clamp_mpp = HAS_S ? PRIV_S : (HAS_U ? PRIV_U : PRIV_M);
            default: clamp_mpp = HAS_U ? PRIV_U : PRIV_M;
        endcase
    endfunction

    always_comb begin
        is_sys  = instr_valid && (opcode == 7'b1110011) && (funct3 == 3'b000);
        is_sret = is_sys && (imm_i == 12'h102);
        is_mret = is_sys && (imm_i == 12'h302);
        is_wfi  = is_sys && (imm_i == 12'h105);
        in_m    = (cur_priv == PRIV_M);
        in_s    = (cur_priv == PRIV_S);
        sret_ok = HAS_S && (in_m || (in_s && !mstatus_tsr));
        mret_ok = in_m;
        wfi_ok  = in_m || (in_s && !mstatus_tw);
    end

    assign stall = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            tgt_priv       <= PRIV_M;
            ret_req        <= 1'b0;
            ret_is_mret    <= 1'b0;
            redirect_valid <= 1'b0;
            new_priv       <= PRIV_M;
            illegal_pulse  <= 1'b0;
            fault_pulse    <= 1'b0;
            wfi_active     <= 1'b0;
        end else begin
            illegal_pulse  <= 1'b0;
            fault_pulse    <= 1'b0;
            redirect_valid <= 1'b0;
            if (kill) begin
                state      <= IDLE;
                ret_req    <= 1'b0;
                wfi_active <= 1'b0;
                cnt        <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if ((is_sret && sret_ok) || (is_mret && mret_ok)) begin
                            state       <= REQ;
                            ret_req     <= 1'b1;
                            ret_is_mret <= is_mret;
                            cnt         <= '0;
                            tgt_priv    <= is_mret ? clamp_mpp(mstatus_mpp)
                                                   : (mstatus_spp ? PRIV_S : PRIV_U);
                        end else if (is_wfi && wfi_ok) begin
                            state      <= WFI;
                            wfi_active <= 1'b1;
                        end else if (is_sret || is_mret || is_wfi) begin
                            illegal_pulse <= 1'b1;
                        end
                    end
                    REQ: begin
                        if (csr_ack) begin
                            new_priv <= tgt_priv;
                            state    <= DONE;
                            ret_req  <= 1'b0;
                        end else if (cnt == CNT_LAST) begin
                            fault_pulse <= 1'b1;
                            state       <= IDLE;
                            ret_req     <= 1'b0;
                            cnt         <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    DONE: begin
                        redirect_valid <= 1'b1;
                        state          <= IDLE;
                    end
                    default: begin
                        if (irq_pending) begin
                            state      <= IDLE;
                            wfi_active <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule
